// File: rtl/simple_fifo_pkg.sv
// Shared sizing helpers for the FIFO front-end blocks.
// id_width keeps a port id at least one bit wide even for degenerate port counts.
package simple_fifo_pkg;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

   function automatic int id_width(input int port_count);
      return (port_count <= 2) ? 1 : clog2(port_count);
   endfunction

endpackage

// File: rtl/simple_rr_arbiter.sv
// Combinational rotating-priority encoder: the port after last_grant_i has top priority.
// Requests are rotated down, the lowest set bit is found, and the offset is rotated back.
module simple_rr_arbiter #(
   parameter int PORT_COUNT = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic [PORT_COUNT-1:0] req_i,
   input  logic [ID_WIDTH-1:0]   last_grant_i,
   output logic [ID_WIDTH-1:0]   winner_o,
   output logic                  any_req_o
);

   localparam logic [ID_WIDTH-1:0] LAST_PORT  = ID_WIDTH'(PORT_COUNT - 1);
   localparam logic [ID_WIDTH:0]   PORT_CNT_W = (ID_WIDTH + 1)'(PORT_COUNT);

   logic [2*PORT_COUNT-1:0] req_dbl;
   logic [PORT_COUNT-1:0]   req_rot;
   logic [ID_WIDTH-1:0]     start;
   logic [ID_WIDTH-1:0]     offset;
   logic [ID_WIDTH:0]       sum;

   always_comb begin
      start   = (last_grant_i >= LAST_PORT) ? '0 : last_grant_i + 1'b1;
      req_dbl = {req_i, req_i};
      req_rot = req_dbl[start +: PORT_COUNT];
      offset  = '0;
      for (int i = PORT_COUNT - 1; i >= 0; i--) begin
         if (req_rot[i]) offset = ID_WIDTH'(i);
      end
      sum = {1'b0, start} + {1'b0, offset};
      if (sum >= PORT_CNT_W) sum = sum - PORT_CNT_W;
      winner_o  = sum[ID_WIDTH-1:0];
      any_req_o = |req_i;
   end

endmodule

// File: rtl/simple_rr_stream_mux.sv
// Round-robin stream mux feeding one shared FIFO write port through a registered, id-tagged stage.
// state | meaning: IDLE = arbitrate among requesters; GRANT = forward beats from grant_id until release.
module simple_rr_stream_mux
   import simple_fifo_pkg::*;
#(
   parameter int PORT_COUNT = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = id_width(PORT_COUNT)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_data,
   input  logic [PORT_COUNT-1:0]            s_valid,
   input  logic [PORT_COUNT-1:0]            s_last,
   output logic [PORT_COUNT-1:0]            s_ready,
   output logic [DATA_WIDTH-1:0]            m_data,
   output logic [ID_WIDTH-1:0]              m_id,
   output logic                             m_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             grant_active,
   output logic [ID_WIDTH-1:0]              grant_id
);

   localparam int              BCW       = clog2(MAX_BURST + 1);
   localparam logic [BCW-1:0]  BEAT_LAST = BCW'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state_q, state_d;
   logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
   logic                    grant_active_q, grant_active_d;
   logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
   logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
   logic                    m_last_q, m_last_d;
   logic                    m_valid_q, m_valid_d;

   logic                    g_valid, g_last, out_free, granted, accept;
   logic [ID_WIDTH-1:0]     winner;
   logic                    any_req;

   simple_rr_arbiter #(
      .PORT_COUNT (PORT_COUNT),
      .ID_WIDTH   (ID_WIDTH)
   ) u_arb (
      .req_i        (s_valid),
      .last_grant_i (last_grant_q),
      .winner_o     (winner),
      .any_req_o    (any_req)
   );

   always_comb begin
      g_valid  = s_valid[grant_id_q];
      g_last   = s_last[grant_id_q];
      out_free = ~m_valid_q | m_ready;
      granted  = (state_q == GRANT);
      accept   = granted & g_valid & out_free & ~rst;
   end

   always_comb begin
      s_ready = '0;
      if (granted && out_free && !rst) s_ready[grant_id_q] = 1'b1;
   end

   always_comb begin
      state_d        = state_q;
      grant_id_d     = grant_id_q;
      grant_active_d = grant_active_q;
      beat_cnt_d     = beat_cnt_q;
      last_grant_d   = last_grant_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_id_d     = winner;
               grant_active_d = 1'b1;
               beat_cnt_d     = '0;
               state_d        = GRANT;
            end
         end
         GRANT: begin
            // An idle granted port releases immediately so it cannot block others.
            if (!g_valid || (accept && (g_last || beat_cnt_q == BEAT_LAST))) begin
               last_grant_d   = grant_id_q;
               grant_active_d = 1'b0;
               state_d        = IDLE;
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_data_d  = m_data_q;
      m_id_d    = m_id_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      if (accept) begin
         m_data_d  = s_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
         m_id_d    = grant_id_q;
         m_last_d  = g_last;
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         grant_id_q     <= '0;
         grant_active_q <= 1'b0;
         beat_cnt_q     <= '0;
         last_grant_q   <= ID_WIDTH'(PORT_COUNT - 1);
         m_data_q       <= '0;
         m_id_q         <= '0;
         m_last_q       <= 1'b0;
         m_valid_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_id_q     <= grant_id_d;
         grant_active_q <= grant_active_d;
         beat_cnt_q     <= beat_cnt_d;
         last_grant_q   <= last_grant_d;
         m_data_q       <= m_data_d;
         m_id_q         <= m_id_d;
         m_last_q       <= m_last_d;
         m_valid_q      <= m_valid_d;
      end
   end

   assign m_data       = m_data_q;
   assign m_id         = m_id_q;
   assign m_last       = m_last_q;
   assign m_valid      = m_valid_q;
   assign grant_active = grant_active_q;
   assign grant_id     = grant_id_q;

endmodule

// File: doc/simple_rr_stream_mux.md
Name: simple_rr_stream_mux

Overview:
- Round-robin scheduler that shares one simple_fifo (or simple_sync_fifo) write port between PORT_COUNT requesters.
- Each requester presents a valid/ready stream. The block grants one port at a time and holds the grant for a packet (s_last) or up to MAX_BURST beats.
- Winning beats are forwarded through a single registered output stage tagged with the source port id.
- Sits in front of shared descriptor and message FIFOs in the core interconnect.

Parameters:
- PORT_COUNT, 4: number of requesting streams, 2..16.
- DATA_WIDTH, 64: beat width.
- MAX_BURST, 4: maximum beats per grant before forced rotation, >=1.
- ID_WIDTH, $clog2(PORT_COUNT): width of m_id.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_data  in  PORT_COUNT*DATA_WIDTH  concatenated input beats, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_valid  in  PORT_COUNT  per-port valid
- s_last  in  PORT_COUNT  per-port end of packet
- s_ready  out  PORT_COUNT  per-port ready
- m_data  out  DATA_WIDTH  registered output beat
- m_id  out  ID_WIDTH  source port of m_data
- m_last  out  1  registered s_last of the beat
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready (FIFO din_ready)
- grant_active  out  1  a port currently holds the grant
- grant_id  out  ID_WIDTH  currently granted port

Behaviour:
- Reset rst, synchronous, active-high; clock clk. All state is on posedge clk.
- Reset values: m_valid=0, m_data=0, m_id=0, m_last=0, s_ready=0, grant_active=0, grant_id=0, state=IDLE, beat_cnt=0, last_grant=PORT_COUNT-1 (so port 0 wins first).
- A reset asserted mid-burst drops the held output beat and returns to IDLE. s_ready is forced 0 while rst is high.
- Beat transfer (accept) = s_valid[g] & s_ready[g].
- s_ready[g] = (state==GRANT) & (grant_id==g) & (~m_valid | m_ready). All other bits are 0.
- Output register loads on accept: m_data, m_id=g, m_last=s_last[g], m_valid=1.
- m_valid clears when m_ready=1 and no new accept occurs in the same cycle. Simultaneous pop and accept keeps m_valid=1 with the new beat.
- Full throughput within a burst: 1 beat/cycle while m_ready=1.
- While m_valid=1 and m_ready=0: m_data, m_id and m_last are stable and s_ready=0.
- State machine:
  - IDLE: if any s_valid, pick the first requesting port scanning from last_grant+1 upward (mod PORT_COUNT). Then grant_id<=winner, grant_active<=1, beat_cnt<=0, state<=GRANT. No requests: stay.
  - GRANT, release on any of:
    - accept with s_last[g]=1;
    - accept with beat_cnt==MAX_BURST-1;
    - s_valid[g]=0 (the granted port went idle; no lock on an idle port).
  - On release: last_grant<=grant_id, grant_active<=0, state<=IDLE.
  - Otherwise, on accept: beat_cnt<=beat_cnt+1.
- Latency: request to first accept is 2 cycles (IDLE decision, then GRANT). Accept to m_valid is 1 cycle. A 1-cycle arbitration bubble follows every release.
- Fairness:
  - A port that released is lowest priority at the next arbitration.
  - With all ports requesting continuously, grants rotate 0,1,2,...,PORT_COUNT-1,0.
- beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
- MAX_BURST=1 forces rotation every beat.

Decomposition:
- Shared package simple_fifo_pkg: clog2 helper function and the default ID_WIDTH derivation. No typedefs are needed.
- One natural sub-module, simple_rr_arbiter:
  - parameters PORT_COUNT, ID_WIDTH;
  - inputs: request vector, last_grant;
  - outputs: winner index and any_req;
  - purely combinational rotate-priority-rotate-back encoder.
- Top level holds the FSM, beat counter, last_grant register and output register.

Test Plan:
- Reset then s_valid=4'b0001 with 3 beats, last on beat 3 -> first s_ready[0] 2 cycles after rst deassert; m_id=0 on 3 consecutive m_valid cycles; m_last=1 on beat 3 only.
- All 4 ports valid continuously, no s_last, MAX_BURST=4, m_ready=1 -> 4 beats per port; m_id sequence 0x4,1x4,2x4,3x4,0...; one bubble cycle between bursts.
- Port 2 granted, m_ready held 0 for 5 cycles mid-burst -> m_data/m_id frozen, s_ready=0. Resume with no lost or duplicated beat; beat_cnt continues from its previous value.
- Ports 1 and 3 valid; port 1 drops s_valid after 1 beat -> grant releases; next grant goes to port 3 (scan from 2) even though port 1 re-asserts valid.
- rst asserted while m_valid=1 and in GRANT -> next cycle m_valid=0, s_ready=0, grant_active=0. After release, port 0 wins first if it requests.
- MAX_BURST=1, ports 0 and 1 valid -> m_id alternates 0,1,0,1 with one bubble between beats.
